// File: rtl/dsp_bank_arbiter_if.sv
// Bundle between two compute engines, the bank arbiter and the shared DSP bank.
// Operands/results are per-lane two's-complement values packed lane-major.
interface dsp_bank_arbiter_if #(
    parameter int LANES = 5
);
    logic [1:0]             req;
    logic [1:0]             gnt;
    logic [1:0]             ce_r;
    logic [LANES-1:0][17:0] a_r0;
    logic [LANES-1:0][17:0] b_r0;
    logic [LANES-1:0][17:0] a_r1;
    logic [LANES-1:0][17:0] b_r1;
    logic [LANES-1:0][36:0] out_r;
    logic [1:0]             out_valid;
    logic [LANES-1:0][17:0] dsp_a0;
    logic [LANES-1:0][17:0] dsp_b0;
    logic                   dsp_ce;
    logic [LANES-1:0][36:0] dsp_out;
    logic                   busy;

    // Arbiter side
    modport slave (
        input  req, ce_r, a_r0, b_r0, a_r1, b_r1, dsp_out,
        output gnt, out_r, out_valid, dsp_a0, dsp_b0, dsp_ce, busy
    );

    // Engines plus DSP bank side
    modport master (
        output req, ce_r, a_r0, b_r0, a_r1, b_r1, dsp_out,
        input  gnt, out_r, out_valid, dsp_a0, dsp_b0, dsp_ce, busy
    );
endinterface

// File: rtl/dsp_bank_arbiter.sv
// Purpose: round-robin owner of one DSP lane bank for two engines, hold-limited, with result tagging.
// Latency: gnt 1 cycle after req; operands/ce combinational to bank; out_valid DSP_LAT cycles after dsp_ce.
// Backpressure: engines stall on gnt low and hold operands; the bank and tag pipe never stall.
module dsp_bank_arbiter #(
    parameter int LANES    = 5,
    parameter int DSP_LAT  = 1,
    parameter int MAX_HOLD = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    dsp_bank_arbiter_if.slave bus
);
    localparam int            HW        = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

    typedef struct packed {
        logic vld;
        logic own;
    } tag_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic [HW-1:0]      hold_q, hold_d;
    tag_t [DSP_LAT-1:0] tag_q;
    tag_t               tag_tail;
    logic               owner;
    logic [1:0]         gnt;
    logic               busy_w;

    assign owner = (state_q == OWN1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // last_q names the requester most recently granted; ties go to the other one.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (bus.req == 2'b11) begin
                    state_d = last_q ? OWN0 : OWN1;
                    last_d  = ~last_q;
                end else if (bus.req[0]) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (bus.req[1]) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (!bus.req[owner]) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (bus.req[~owner]) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = GAP;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            GAP: begin
                hold_d = '0;
                if (bus.req[~last_q]) begin
                    state_d = last_q ? OWN0 : OWN1;
                    last_d  = ~last_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    assign gnt        = {state_q == OWN1, state_q == OWN0};
    assign bus.gnt    = gnt;
    assign bus.dsp_ce = |(bus.ce_r & gnt);
    assign bus.dsp_a0 = gnt[0] ? bus.a_r0 : (gnt[1] ? bus.a_r1 : '0);
    assign bus.dsp_b0 = gnt[0] ? bus.b_r0 : (gnt[1] ? bus.b_r1 : '0);

    // Tags travel alongside the bank pipeline so results follow the issuer, not the current owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= '{vld: bus.dsp_ce, own: owner};
            for (int i = 1; i < DSP_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_tail      = tag_q[DSP_LAT-1];
    assign bus.out_valid = {tag_tail.vld & tag_tail.own, tag_tail.vld & ~tag_tail.own};
    assign bus.out_r     = bus.dsp_out;

    always_comb begin
        busy_w = 1'b0;
        for (int i = 0; i < DSP_LAT; i++) begin
            busy_w = busy_w | tag_q[i].vld;
        end
    end

    assign bus.busy = busy_w;
endmodule

// File: tb/tb_dsp_bank_arbiter.sv
// Directed bench: three arbiter instances (LAT1/HOLD4, LAT3/HOLD4, LAT2/HOLD64) on a shared clock and reset.
module tb_dsp_bank_arbiter;
    localparam int          LANES = 5;
    localparam logic [17:0] NEG4  = 18'(-4);
    localparam logic [36:0] NEG12 = 37'(-12);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   a_ov1_cnt = 0;
    int   c_ov_cnt  = 0;

    logic [1:0] preempt_exp [14] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                                     2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                                     2'b01, 2'b01, 2'b01, 2'b01};
    logic [1:0] b_ce   [7] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    logic       b_dce  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0] b_gnt  [7] = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
    logic [1:0] b_ov   [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    logic       b_busy [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    dsp_bank_arbiter_if #(.LANES(LANES)) ifa ();
    dsp_bank_arbiter_if #(.LANES(LANES)) ifb ();
    dsp_bank_arbiter_if #(.LANES(LANES)) ifc ();

    dsp_bank_arbiter #(.LANES(LANES), .DSP_LAT(1), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    dsp_bank_arbiter #(.LANES(LANES), .DSP_LAT(3), .MAX_HOLD(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));
    dsp_bank_arbiter #(.LANES(LANES), .DSP_LAT(2), .MAX_HOLD(64)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc));

    // Single-stage signed multiplier bank model for instance A
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifa.dsp_out <= '0;
        end else if (ifa.dsp_ce) begin
            for (int i = 0; i < LANES; i++) begin
                ifa.dsp_out[i] <= {{19{ifa.dsp_a0[i][17]}}, ifa.dsp_a0[i]} *
                                  {{19{ifa.dsp_b0[i][17]}}, ifa.dsp_b0[i]};
            end
        end
    end

    always @(negedge clk) begin
        if (ifa.out_valid[1]) a_ov1_cnt++;
        if (ifc.out_valid != 2'b00) c_ov_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifa.req = '0; ifa.ce_r = '0; ifa.a_r0 = '0; ifa.b_r0 = '0; ifa.a_r1 = '0; ifa.b_r1 = '0;
        ifb.req = '0; ifb.ce_r = '0; ifb.a_r0 = '0; ifb.b_r0 = '0; ifb.a_r1 = '0; ifb.b_r1 = '0;
        ifc.req = '0; ifc.ce_r = '0; ifc.a_r0 = '0; ifc.b_r0 = '0; ifc.a_r1 = '0; ifc.b_r1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        ifb.dsp_out = '0;
        ifc.dsp_out = '0;
        rst_n = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < LANES; i++) begin
            ifa.a_r0[i] = 18'd9;
            ifb.a_r1[i] = 18'd9;
        end
        #1;
        check("rst_gnt_a",  ifa.gnt, 2'b00);
        check("rst_gnt_b",  ifb.gnt, 2'b00);
        check("rst_ov_a",   ifa.out_valid, 2'b00);
        check("rst_busy_b", ifb.busy, 1'b0);
        check("rst_dce_a",  ifa.dsp_ce, 1'b0);
        check("rst_da0_a",  ifa.dsp_a0, '0);
        check("rst_db0_b",  ifb.dsp_a0, '0);

        // Single requester on A
        idle_inputs();
        rst_n = 1'b1;                      // cycle 0
        cyc();                             // cycle 1
        cyc(); ifa.req = 2'b01;            // cycle 2
        cyc(); check("single_gnt_c3", ifa.gnt, 2'b01);
        cyc();                             // cycle 4
        ifa.ce_r = 2'b01;
        for (int i = 0; i < LANES; i++) begin
            ifa.a_r0[i] = 18'd3;
            ifa.b_r0[i] = NEG4;
        end
        #1;
        check("single_dce_c4", ifa.dsp_ce, 1'b1);
        check("single_da0_c4", ifa.dsp_a0[2], 18'd3);
        check("single_ov_c4",  ifa.out_valid, 2'b00);
        cyc(); ifa.ce_r = 2'b00; #1;       // cycle 5
        check("single_ov_c5",   ifa.out_valid, 2'b01);
        check("single_busy_c5", ifa.busy, 1'b1);
        for (int i = 0; i < LANES; i++) begin
            check($sformatf("single_out_r[%0d]", i), ifa.out_r[i], NEG12);
        end
        cyc();                             // cycle 6
        check("single_ov_c6",   ifa.out_valid, 2'b00);
        check("single_busy_c6", ifa.busy, 1'b0);
        ifa.req = 2'b00;
        cyc(); check("single_gnt_rel", ifa.gnt, 2'b00);

        // Simultaneous requests, then release by the owner
        do_reset();
        ifa.req = 2'b11;
        cyc(); check("both_gnt_first", ifa.gnt, 2'b01);
        cyc(); check("both_gnt_hold",  ifa.gnt, 2'b01);
        ifa.req = 2'b10;
        cyc(); check("both_gnt_n1", ifa.gnt, 2'b00);
        cyc(); check("both_gnt_n2", ifa.gnt, 2'b10);
        ifa.req = 2'b00;
        cyc(); check("both_gnt_rel", ifa.gnt, 2'b00);

        // Hold-limit preemption, MAX_HOLD=4, 20 cycles of contention
        do_reset();
        ifa.req = 2'b11;
        for (int i = 0; i < 14; i++) begin
            cyc();
            check($sformatf("preempt_gnt[%0d]", i), ifa.gnt, preempt_exp[i]);
        end
        for (int i = 0; i < 6; i++) cyc();
        ifa.req = 2'b00;

        // Non-owner strobe and operands must be ignored
        do_reset();
        ifa.req = 2'b01;
        cyc();
        for (int i = 0; i < LANES; i++) begin
            ifa.a_r0[i] = 18'd5;
            ifa.b_r0[i] = 18'd2;
            ifa.a_r1[i] = 18'd7;
            ifa.b_r1[i] = 18'd9;
        end
        ifa.ce_r = 2'b10;
        #1;
        check("nonown_gnt", ifa.gnt, 2'b01);
        check("nonown_dce", ifa.dsp_ce, 1'b0);
        check("nonown_da0", ifa.dsp_a0[0], 18'd5);
        check("nonown_da4", ifa.dsp_a0[4], 18'd5);
        check("nonown_db0", ifa.dsp_b0[3], 18'd2);
        cyc();
        check("nonown_ov",   ifa.out_valid, 2'b00);
        check("nonown_busy", ifa.busy, 1'b0);

        // DSP_LAT=3: results cross a preemption and still route to their issuers
        do_reset();
        ifb.req = 2'b11;
        cyc(); cyc(); cyc();
        for (int j = 0; j < 7; j++) begin
            cyc();
            ifb.ce_r = b_ce[j];
            #1;
            check($sformatf("lat3_gnt[%0d]", j),  ifb.gnt, b_gnt[j]);
            check($sformatf("lat3_dce[%0d]", j),  ifb.dsp_ce, b_dce[j]);
            check($sformatf("lat3_ov[%0d]", j),   ifb.out_valid, b_ov[j]);
            check($sformatf("lat3_busy[%0d]", j), ifb.busy, b_busy[j]);
        end
        ifb.req = 2'b00;

        // Reset in the middle of a burst on DSP_LAT=2
        do_reset();
        ifc.req = 2'b01;
        for (int i = 0; i < LANES; i++) begin
            ifc.a_r0[i] = 18'd1;
            ifc.b_r0[i] = 18'd1;
        end
        cyc(); check("rst_mid_gnt", ifc.gnt, 2'b01);
        cyc(); ifc.ce_r = 2'b01; #1;
        check("rst_mid_dce1", ifc.dsp_ce, 1'b1);
        cyc(); #1;
        check("rst_mid_busy_pre", ifc.busy, 1'b1);
        check("rst_mid_dce2",     ifc.dsp_ce, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_gnt0",  ifc.gnt, 2'b00);
        check("rst_mid_busy0", ifc.busy, 1'b0);
        check("rst_mid_ov0",   ifc.out_valid, 2'b00);
        check("rst_mid_dce0",  ifc.dsp_ce, 1'b0);
        check("rst_mid_da0",   ifc.dsp_a0, '0);
        cyc();
        cyc();
        ifc.ce_r = 2'b00;
        rst_n = 1'b1;
        check("rst_mid_ov_rel", ifc.out_valid, 2'b00);
        cyc(); check("rst_mid_gnt_after", ifc.gnt, 2'b01);
        check("rst_mid_ov_after", ifc.out_valid, 2'b00);
        cyc(); check("rst_mid_ov_after2", ifc.out_valid, 2'b00);
        ifc.req = 2'b00;
        cyc();
        cyc();

        check("a_ov1_never_high", a_ov1_cnt, 0);
        check("c_ov_never_high",  c_ov_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
